// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - command/response front end driving a single APB initiator port
//
// Purpose:
//    Accepts one command at a time (address, direction, write data, byte
//    strobes), runs it as an APB SETUP/ACCESS transfer and returns a single
//    response (read data, error, timeout) held until the consumer takes it.
//    All outputs are registered. The FSM states are IDLE, SETUP, ACCESS and RESP.
//
// Optional feature:
//    APB_CMD_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that sees no
//    PREADY for TIMEOUT_CYCLES cycles is aborted and answered with
//    rsp_err=1, rsp_timeout=1, rsp_rdata=0. When undefined, ACCESS waits
//    indefinitely and rsp_timeout is tied to 0.
//
// Ports:
//    clk_in, reset_n        clock (rising edge), synchronous active-low reset
//    cmd_valid/cmd_ready    command handshake
//    cmd_addr/cmd_write     target address, 1 = write
//    cmd_wdata/cmd_strb     write data and byte strobes
//    rsp_valid/rsp_ready    response handshake
//    rsp_rdata/rsp_err      read data (0 for writes), slave error or timeout
//    rsp_timeout            transfer aborted by timeout
//    PADDR..PSTRB           APB initiator outputs
//    PRDATA/PREADY/PSLVERR  APB completer inputs (sampled only in ACCESS)

module apb_cmd_master #(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_in,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  logic [31:0]           cmd_wdata,
   input  logic [3:0]            cmd_strb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [31:0]           PWDATA,
   output logic [3:0]            PSTRB,
   input  logic [31:0]           PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("apb_cmd_master: TIMEOUT_CYCLES out of range 1..65535");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t state;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
   // The counter holds the number of PREADY=0 ACCESS cycles already seen, so
   // the abort fires on the cycle that would make it reach TIMEOUT_CYCLES.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] to_cnt;
`else
   assign rsp_timeout = 1'b0;
`endif

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         cmd_ready   <= 1'b1;
         PADDR       <= '0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PWDATA      <= 32'd0;
         PSTRB       <= 4'd0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 32'd0;
         rsp_err     <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
         rsp_timeout <= 1'b0;
         to_cnt      <= 16'd0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  PADDR     <= cmd_addr;
                  PWRITE    <= cmd_write;
                  // Reads never expose stale write data or strobes on the bus.
                  PWDATA    <= cmd_write ? cmd_wdata : 32'd0;
                  PSTRB     <= cmd_write ? cmd_strb : 4'd0;
                  PSEL      <= 1'b1;
                  PENABLE   <= 1'b0;
                  cmd_ready <= 1'b0;
                  state     <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               PENABLE <= 1'b1;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
               to_cnt  <= 16'd0;
`endif
               state   <= ST_ACCESS;
            end

            ST_ACCESS: begin
               // PREADY wins over a timeout reached in the same cycle.
               if (PREADY) begin
                  rsp_rdata   <= PWRITE ? 32'd0 : PRDATA;
                  rsp_err     <= PSLVERR;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                  rsp_timeout <= 1'b0;
`endif
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  state       <= ST_RESP;
               end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  rsp_rdata   <= 32'd0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  state       <= ST_RESP;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
`endif
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - self-checking bench for apb_cmd_master

module tb_apb_cmd_master;

   localparam int AW = 16;

   logic          clk_in = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic          cmd_write = 1'b0;
   logic [31:0]   cmd_wdata = 32'd0;
   logic [3:0]    cmd_strb = 4'd0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic [AW-1:0] PADDR;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [31:0]   PWDATA;
   logic [3:0]    PSTRB;
   logic [31:0]   PRDATA = 32'd0;
   logic          PREADY = 1'b1;
   logic          PSLVERR = 1'b1;

   apb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
      .clk_in(clk_in), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk_in) cyc++;

   // Slave behaviour knobs
   int          slv_wait = 0;
   bit          slv_stuck = 1'b0;
   logic [31:0] slv_rdata = 32'd0;
   logic        slv_err = 1'b0;

   // Bus monitor results
   int            setup_cnt = 0;
   int            acc_cnt = 0;
   bit            stable = 1'b1;
   logic [AW-1:0] snap_addr;
   logic          snap_write;
   logic [31:0]   snap_wdata;
   logic [3:0]    snap_strb;
   int            setup_cyc_q[$];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } rsp_t;
   rsp_t exp_q[$];

   // Completer model: PREADY/PSLVERR are driven high outside ACCESS so any
   // use of them there would show up as a wrong response.
   initial begin : slave
      int wcnt;
      wcnt = 0;
      forever begin
         @(negedge clk_in);
         if (PSEL && PENABLE) begin
            PREADY  = !slv_stuck && (wcnt >= slv_wait);
            PRDATA  = slv_rdata;
            PSLVERR = slv_err;
            wcnt++;
         end else begin
            wcnt    = 0;
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
            PRDATA  = 32'hBAD0_BAD0;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk_in);
         if (PSEL && !PENABLE) begin
            setup_cnt++;
            acc_cnt    = 0;
            stable     = 1'b1;
            snap_addr  = PADDR;
            snap_write = PWRITE;
            snap_wdata = PWDATA;
            snap_strb  = PSTRB;
            setup_cyc_q.push_back(cyc);
         end else if (PSEL && PENABLE) begin
            acc_cnt++;
            if (PADDR !== snap_addr || PWRITE !== snap_write ||
                PWDATA !== snap_wdata || PSTRB !== snap_strb)
               stable = 1'b0;
         end
      end
   end

   task automatic do_reset();
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk_in);
      reset_n = 1'b1;
      @(negedge clk_in);
   endtask

   // kind: 0 = normal response expected, 1 = timeout response, 2 = none
   task automatic send_cmd(input logic [AW-1:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s,
                           input int kind, output int acc_cyc);
      rsp_t e;
      bit   ok;
      ok        = 1'b0;
      acc_cyc   = 0;
      cmd_addr  = a;
      cmd_write = w;
      cmd_wdata = d;
      cmd_strb  = s;
      cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            acc_cyc = cyc;
            break;
         end
         @(negedge clk_in);
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL cmd_accept: cmd_ready=%0b, required 1 within 50 cycles", cmd_ready);
      end
      if (kind == 0) begin
         e.rdata = w ? 32'd0 : slv_rdata;
         e.err   = slv_err;
         e.tmo   = 1'b0;
         exp_q.push_back(e);
      end else if (kind == 1) begin
         e.rdata = 32'd0;
         e.err   = 1'b1;
         e.tmo   = 1'b1;
         exp_q.push_back(e);
      end
      @(negedge clk_in);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int rsp_cyc);
      bit seen;
      seen = 1'b0;
      rsp_cyc = 0;
      for (int i = 0; i < 100; i++) begin
         if (rsp_valid) begin
            seen = 1'b1;
            rsp_cyc = cyc;
            break;
         end
         @(negedge clk_in);
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL rsp_wait: rsp_valid=%0b, required 1 within 100 cycles", rsp_valid);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b required 1000000",
                  {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout});
      end
      checks++;
      if (PADDR !== '0 || PWDATA !== 32'd0 || PSTRB !== 4'd0 || rsp_rdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_data: PADDR=%h PWDATA=%h PSTRB=%h rsp_rdata=%h required all 0",
                  PADDR, PWDATA, PSTRB, rsp_rdata);
      end
   endtask

   task automatic test_zero_wait_read();
      int   a_cyc, r_cyc, s0;
      rsp_t e;
      slv_wait  = 0;
      slv_rdata = 32'hA5A5_0001;
      slv_err   = 1'b0;
      s0 = setup_cnt;
      send_cmd(16'h0004, 1'b0, 32'h1234_5678, 4'hF, 0, a_cyc);
      wait_rsp(r_cyc);
      checks++;
      if (r_cyc - a_cyc != 3) begin
         failures++;
         $display("FAIL zw_latency: got %0d cycles required 3", r_cyc - a_cyc);
      end
      checks++;
      if (setup_cnt - s0 != 1 || acc_cnt != 1) begin
         failures++;
         $display("FAIL zw_phases: setup=%0d access=%0d required 1 and 1", setup_cnt - s0, acc_cnt);
      end
      checks++;
      if (snap_addr !== 16'h0004 || snap_write !== 1'b0 || snap_wdata !== 32'd0 || snap_strb !== 4'd0) begin
         failures++;
         $display("FAIL zw_bus: addr=%h write=%b wdata=%h strb=%h required 0004 0 00000000 0",
                  snap_addr, snap_write, snap_wdata, snap_strb);
      end
      e = exp_q.pop_front();
      checks++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err || rsp_timeout !== e.tmo) begin
         failures++;
         $display("FAIL zw_rsp: rdata=%h err=%b tmo=%b required %h %b %b",
                  rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
      end
      rsp_ready = 1'b1;
      @(negedge clk_in);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL zw_release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_write_wait_err();
      int   a_cyc, r_cyc;
      rsp_t e;
      slv_wait  = 2;
      slv_rdata = 32'h1111_2222;
      slv_err   = 1'b1;
      send_cmd(16'h0008, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, a_cyc);
      wait_rsp(r_cyc);
      checks++;
      if (acc_cnt != 3 || !stable) begin
         failures++;
         $display("FAIL ww_access: cycles=%0d stable=%0b required 3 1", acc_cnt, stable);
      end
      checks++;
      if (snap_addr !== 16'h0008 || snap_write !== 1'b1 || snap_wdata !== 32'hDEAD_BEEF || snap_strb !== 4'hF) begin
         failures++;
         $display("FAIL ww_bus: addr=%h write=%b wdata=%h strb=%h required 0008 1 deadbeef f",
                  snap_addr, snap_write, snap_wdata, snap_strb);
      end
      checks++;
      if (r_cyc - a_cyc != 5) begin
         failures++;
         $display("FAIL ww_latency: got %0d cycles required 5", r_cyc - a_cyc);
      end
      e = exp_q.pop_front();
      checks++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err || rsp_timeout !== e.tmo) begin
         failures++;
         $display("FAIL ww_rsp: rdata=%h err=%b tmo=%b required %h %b %b",
                  rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
      end
      rsp_ready = 1'b1;
      @(negedge clk_in);
      rsp_ready = 1'b0;
      slv_wait = 0;
      slv_err  = 1'b0;
   endtask

   task automatic test_backpressure();
      int   a_cyc, r_cyc, r, n0;
      rsp_t e, e2;
      slv_wait  = 0;
      slv_rdata = 32'h0BAD_F00D;
      slv_err   = 1'b0;
      send_cmd(16'h0010, 1'b0, 32'd0, 4'd0, 0, a_cyc);
      wait_rsp(r_cyc);
      e = exp_q.pop_front();
      cmd_addr  = 16'h0014;
      cmd_write = 1'b1;
      cmd_wdata = 32'hCAFE_0000;
      cmd_strb  = 4'h3;
      cmd_valid = 1'b1;
      n0 = setup_cyc_q.size();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err ||
             cmd_ready !== 1'b0 || setup_cyc_q.size() != n0) begin
            failures++;
            $display("FAIL bp_hold: valid=%b rdata=%h err=%b cmd_ready=%b required 1 %h %b 0",
                     rsp_valid, rsp_rdata, rsp_err, cmd_ready, e.rdata, e.err);
         end
      end
      e2.rdata = 32'd0;
      e2.err   = 1'b0;
      e2.tmo   = 1'b0;
      exp_q.push_back(e2);
      rsp_ready = 1'b1;
      r = cyc;
      @(negedge clk_in);
      rsp_ready = 1'b0;
      @(negedge clk_in);
      cmd_valid = 1'b0;
      checks++;
      if (setup_cyc_q.size() != n0 + 1 || setup_cyc_q[setup_cyc_q.size()-1] != r + 2) begin
         failures++;
         $display("FAIL bp_next_setup: setups=%0d at cycle offset %0d required 1 at 2",
                  setup_cyc_q.size() - n0,
                  (setup_cyc_q.size() > 0) ? setup_cyc_q[setup_cyc_q.size()-1] - r : -1);
      end
      wait_rsp(r_cyc);
      e = exp_q.pop_front();
      checks++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
         failures++;
         $display("FAIL bp_second_rsp: rdata=%h err=%b required %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
      rsp_ready = 1'b1;
      @(negedge clk_in);
      rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addrs [3] = '{16'h0100, 16'h0104, 16'h0108};
      logic          wrs   [3] = '{1'b0, 1'b1, 1'b0};
      int   n0, sent, got;
      bit   pend;
      rsp_t e;
      slv_wait  = 0;
      slv_rdata = 32'h5A5A_1234;
      slv_err   = 1'b0;
      n0   = setup_cyc_q.size();
      sent = 0;
      got  = 0;
      pend = 1'b0;
      rsp_ready = 1'b1;
      cmd_addr  = addrs[0];
      cmd_write = wrs[0];
      cmd_wdata = 32'h7777_0000;
      cmd_strb  = 4'hF;
      cmd_valid = 1'b1;
      for (int i = 0; i < 60 && got < 3; i++) begin
         if (pend) begin
            pend = 1'b0;
            sent++;
            if (sent < 3) begin
               cmd_addr  = addrs[sent];
               cmd_write = wrs[sent];
            end else begin
               cmd_valid = 1'b0;
            end
         end
         if (rsp_valid) begin
            e = exp_q.pop_front();
            got++;
            checks++;
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
               failures++;
               $display("FAIL b2b_rsp%0d: rdata=%h err=%b required %h %b", got, rsp_rdata, rsp_err, e.rdata, e.err);
            end
         end
         if (cmd_valid && cmd_ready) begin
            e.rdata = cmd_write ? 32'd0 : slv_rdata;
            e.err   = 1'b0;
            e.tmo   = 1'b0;
            exp_q.push_back(e);
            pend = 1'b1;
         end
         @(negedge clk_in);
      end
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      checks++;
      if (got != 3) begin
         failures++;
         $display("FAIL b2b_count: got %0d responses required 3", got);
      end
      checks++;
      if (setup_cyc_q.size() < n0 + 3 ||
          setup_cyc_q[n0+1] - setup_cyc_q[n0] != 4 ||
          setup_cyc_q[n0+2] - setup_cyc_q[n0+1] != 4) begin
         failures++;
         $display("FAIL b2b_period: setups=%0d required 3 spaced 4 cycles apart", setup_cyc_q.size() - n0);
      end
   endtask

   task automatic test_timeout();
      int a_cyc, r_cyc;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      rsp_t e;
      slv_stuck = 1'b1;
      send_cmd(16'h0020, 1'b0, 32'd0, 4'd0, 1, a_cyc);
      wait_rsp(r_cyc);
      checks++;
      if (acc_cnt != 4 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
         failures++;
         $display("FAIL to_abort: access=%0d PSEL=%b PENABLE=%b required 4 0 0", acc_cnt, PSEL, PENABLE);
      end
      e = exp_q.pop_front();
      checks++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err || rsp_timeout !== e.tmo) begin
         failures++;
         $display("FAIL to_rsp: rdata=%h err=%b tmo=%b required %h %b %b",
                  rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
      end
      rsp_ready = 1'b1;
      @(negedge clk_in);
      rsp_ready = 1'b0;
      slv_stuck = 1'b0;
`else
      bit any_rsp;
      any_rsp   = 1'b0;
      r_cyc     = 0;
      slv_stuck = 1'b1;
      send_cmd(16'h0020, 1'b0, 32'd0, 4'd0, 2, a_cyc);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_in);
         if (rsp_valid) any_rsp = 1'b1;
      end
      checks++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1 || any_rsp || rsp_timeout !== 1'b0) begin
         failures++;
         $display("FAIL no_timeout: PSEL=%b PENABLE=%b rsp_seen=%0b tmo=%b required 1 1 0 0",
                  PSEL, PENABLE, any_rsp, rsp_timeout);
      end
      slv_stuck = 1'b0;
      do_reset();
`endif
   endtask

   task automatic test_reset_in_access();
      int a_cyc;
      bit any_rsp;
      any_rsp   = 1'b0;
      slv_stuck = 1'b1;
      send_cmd(16'h0030, 1'b1, 32'h0102_0304, 4'hF, 2, a_cyc);
      repeat (2) @(negedge clk_in);
      checks++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
         failures++;
         $display("FAIL ra_pre: PSEL=%b PENABLE=%b required 1 1", PSEL, PENABLE);
      end
      reset_n = 1'b0;
      @(negedge clk_in);
      reset_n   = 1'b1;
      slv_stuck = 1'b0;
      checks++;
      if (PSEL !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL ra_after: PSEL=%b PENABLE=%b cmd_ready=%b rsp_valid=%b required 0 0 1 0",
                  PSEL, PENABLE, cmd_ready, rsp_valid);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_in);
         if (rsp_valid) any_rsp = 1'b1;
      end
      checks++;
      if (any_rsp) begin
         failures++;
         $display("FAIL ra_no_rsp: rsp_valid seen=%0b required 0", any_rsp);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_zero_wait_read();
      test_write_wait_err();
      test_backpressure();
      test_back_to_back();
      test_timeout();
      test_reset_in_access();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_empty: %0d expected responses outstanding, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
